mac_in_driver: RTL and testbench
================================

Name: mac_in_driver

Overview:
- Transmit side of the MAC array west-edge interface. Produces the `in_w` / `inst_w` stream that the array consumes.
- Kernel load: accepts one packed source word per kernel column. Each word carries one 8-bit weight byte per row. The block splits each word into two 4-bit beats, low nibbles first and high nibbles second, and tags both beats `inst_w=2'b01`. The array pairs the two beats back into bytes.
- Execute: forwards one activation word per beat, tagged `inst_w=2'b10`.
- Sits between the L0/input SRAM read path and the MAC array.

Parameters:
- bw, 4, activation/weight nibble width per row lane.
- row, 8, number of array rows (lanes per beat).
- col, 8, number of kernel columns per load phase (source words per load).
- cnt_bw, 8, width of the execute beat counter and of `num_exec`.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- start_load  input  1  single-cycle request to begin a kernel load phase.
- start_exec  input  1  single-cycle request to begin an execute phase.
- num_exec  input  cnt_bw  number of execute beats; sampled when `start_exec` is accepted.
- src_data  input  row*bw*2  source word. In load mode, row i byte = bits [8i+7:8i]. In execute mode, only bits [row*bw-1:0] are used.
- src_valid  input  1  `src_data` valid.
- src_ready  output  1  block accepts `src_data` this cycle.
- in_w  output  row*bw  beat to the array; lane i = bits [bw*i+bw-1:bw*i].
- inst_w  output  2  01 = load beat, 10 = execute beat, 00 = bubble.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse at the end of a phase.

Behaviour:
- Clocking and reset: one clock `clk`; reset is synchronous, active-high.
  - Reset values: `in_w`=0, `inst_w`=00, `done`=0, `busy`=0, `src_ready`=0.
  - Reset clears state to IDLE and zeroes all counters and the held word.
  - Reset in mid-pair discards the pending high half. The array is reset on the same edge, so its pairing buffer state stays consistent.
- State machine: IDLE, LOAD_A, LOAD_B, EXEC, DONE.
- Outputs: `in_w`, `inst_w` and `done` are registered. `src_ready` is combinational from state: high only in LOAD_A and EXEC.
- Handshake: a word is accepted when `src_valid && src_ready`. The corresponding beat appears on `in_w` / `inst_w` on the next cycle (latency 1).
- IDLE:
  - `start_load` -> LOAD_A, kernel counter = 0.
  - else `start_exec` -> EXEC, `exec_left` = `num_exec`. If `num_exec`=0, go directly to DONE and emit no beats.
  - Both asserted: load wins; `start_exec` is dropped.
  - Starts are ignored while `busy`.
- LOAD_A:
  - On accept: register `in_w` lane i = `src_data[8i+3:8i]`, `inst_w`=01; hold `src_data` internally; go to LOAD_B.
  - No accept: `inst_w`=00, `in_w` holds.
- LOAD_B:
  - No source handshake.
  - Register `in_w` lane i = held `[8i+7:8i+4]`, `inst_w`=01; increment the kernel counter.
  - Counter reaching col -> DONE, else -> LOAD_A.
  - Guarantee: a beat pair is never split by an execute beat. Bubbles (00) may occur only between pairs.
- EXEC:
  - On accept: `in_w` = `src_data[row*bw-1:0]`, `inst_w`=10, decrement `exec_left`. Reaching 0 -> DONE.
  - No accept: `inst_w`=00.
- DONE: `done`=1 for one cycle, `inst_w`=00, `busy` still 1; next state IDLE.
- Totals: a load phase emits exactly 2*col beats tagged 01. An execute phase emits exactly `num_exec` beats tagged 10. Back-to-back phases are separated by at least the DONE and IDLE cycles.

Test Plan:
- Load, src always valid, word k = all bytes 8'h(k+1)A for k=0..col-1 (k=0 -> 8'h1A, each row i byte = src[8i+7:8i]) -> beats alternate: lanes all 4'hA, then lanes all 4'h(k+1); 16 consecutive `inst_w`=01 beats; `done` pulses 1 cycle after the 16th beat; `src_ready` low on every LOAD_B cycle.
- Load with src_valid toggling 1,0,1,0 -> bubbles (`inst_w`=00) appear only before low beats, never between low and high; reconstructed bytes match the source bytes; 16 load beats total.
- Execute, `num_exec`=5, src low half = 32'h87654321 -> 5 beats `inst_w`=10 with `in_w`=32'h87654321; `done` after the 5th beat; `num_exec`=0 -> `done` 2 cycles after start, no beats.
- `start_load` and `start_exec` in the same IDLE cycle -> load phase only; `start_exec` pulse while busy -> ignored.
- Reset asserted in LOAD_B after 3 pairs -> next cycle `inst_w`=00, `in_w`=0, `busy`=0; a subsequent load restarts at kernel 0.
- Scoreboard: pass the driver output through the array-side pairing model ({second, first} per row) -> recovered weights equal source bytes over 100 random words with random `src_valid`.

Source files
------------

// File: rtl/mac_in_driver.sv
// mac_in_driver: west-edge beat generator for the MAC array (split-nibble kernel load, activation execute)
// Ports: clk/reset (sync, active-high); start_load/start_exec/num_exec start a phase;
//   src_data/src_valid/src_ready source handshake; in_w/inst_w registered beat stream
//   (01 load, 10 execute, 00 bubble); busy = not idle; done = one-cycle end-of-phase pulse.
module mac_in_driver #(
  parameter int bw = 4,
  parameter int row = 8,
  parameter int col = 8,
  parameter int cnt_bw = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_load,
  input  logic                  start_exec,
  input  logic [cnt_bw-1:0]     num_exec,
  input  logic [row*bw*2-1:0]   src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [row*bw-1:0]     in_w,
  output logic [1:0]            inst_w,
  output logic                  busy,
  output logic                  done
);
  localparam int kw = $clog2(col + 1);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic [kw-1:0] kcnt_q, kcnt_d;
  logic [cnt_bw-1:0] exec_left_q, exec_left_d;
  logic [row*bw-1:0] hold_q, hold_d, in_w_q, in_w_d, lo, hi;
  logic [1:0] inst_w_q, inst_w_d;
  logic done_q, done_d, accept;
  for (genvar i = 0; i < row; i++) begin : g_split
    assign lo[bw*i +: bw] = src_data[2*bw*i +: bw];
    assign hi[bw*i +: bw] = src_data[2*bw*i+bw +: bw];
  end
  assign src_ready = state_q == LOAD_A || state_q == EXEC;
  assign accept = src_valid && src_ready;
  assign busy = state_q != IDLE;
  assign in_w = in_w_q;
  assign inst_w = inst_w_q;
  assign done = done_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      kcnt_q <= '0;
      exec_left_q <= '0;
      hold_q <= '0;
      in_w_q <= '0;
      inst_w_q <= 2'b00;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kcnt_q <= kcnt_d;
      exec_left_q <= exec_left_d;
      hold_q <= hold_d;
      in_w_q <= in_w_d;
      inst_w_q <= inst_w_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    kcnt_d = kcnt_q;
    exec_left_d = exec_left_q;
    case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d = LOAD_A;
          kcnt_d = '0;
        end else if (start_exec) begin
          exec_left_d = num_exec;
          state_d = num_exec == '0 ? DONE : EXEC;
        end
      end
      LOAD_A: state_d = accept ? LOAD_B : LOAD_A;
      // The high half always follows immediately, so a pair is never split.
      LOAD_B: begin
        kcnt_d = kcnt_q + 1'b1;
        state_d = kcnt_q == kw'(col - 1) ? DONE : LOAD_A;
      end
      EXEC: begin
        if (accept) begin
          exec_left_d = exec_left_q - 1'b1;
          state_d = exec_left_q == cnt_bw'(1) ? DONE : EXEC;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_w_d = in_w_q;
    inst_w_d = 2'b00;
    hold_d = hold_q;
    done_d = state_q == DONE;
    if (state_q == LOAD_A && accept) begin
      in_w_d = lo;
      inst_w_d = 2'b01;
      hold_d = hi;
    end else if (state_q == LOAD_B) begin
      in_w_d = hold_q;
      inst_w_d = 2'b01;
    end else if (state_q == EXEC && accept) begin
      in_w_d = src_data[row*bw-1:0];
      inst_w_d = 2'b10;
    end
  end
endmodule

// File: tb/tb_mac_in_driver.sv
// tb_mac_in_driver: scoreboard bench pairing load beats back into bytes and checking phase framing
`timescale 1ns/1ps
module tb_mac_in_driver;
  logic clk, reset, start_load, start_exec, src_valid, src_ready, busy, done;
  logic [7:0] num_exec;
  logic [63:0] src_data;
  logic [31:0] in_w;
  logic [1:0] inst_w;
  int ncmp, nerr, load_beats, exec_beats;
  bit mode, pend;
  logic [63:0] load_q[$];
  logic [31:0] exec_q[$];
  logic [63:0] rec, expw;
  logic [31:0] first_b, expe;

  mac_in_driver dut (
    .clk(clk), .reset(reset), .start_load(start_load), .start_exec(start_exec),
    .num_exec(num_exec), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .in_w(in_w), .inst_w(inst_w), .busy(busy), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wordk(input int k);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = {4'(k + 1), 4'hA};
    return v;
  endfunction

  task automatic run_load(input int vmode, input bit with_exec, output int busy_n, output int rdy_n,
                          output int beats, output int early, output bit done_seen, output int words);
    int lb0, t;
    bit acc, was_rdy;
    lb0 = load_beats; busy_n = 0; rdy_n = 0; early = 0; words = 0; t = 0;
    mode = 0;
    src_data = vmode == 0 ? wordk(0) : {$urandom(), $urandom()};
    src_valid = 1; start_load = 1; start_exec = with_exec; num_exec = 3;
    cyc();
    start_load = 0; start_exec = 0;
    while (busy && t < 200) begin
      busy_n++;
      if (src_ready) rdy_n++;
      if (done) early++;
      acc = src_valid && src_ready;
      was_rdy = src_ready;
      if (with_exec && t == 3) start_exec = 1;
      cyc();
      start_exec = 0; t++;
      if (acc) begin
        words++;
        src_data = vmode == 0 ? wordk(words) : {$urandom(), $urandom()};
      end
      if (vmode == 1 && was_rdy) src_valid = ~src_valid;
      if (vmode == 2) src_valid = 1'($urandom_range(0, 1));
    end
    done_seen = done;
    src_valid = 0;
    cyc();
    beats = load_beats - lb0;
  endtask

  task automatic run_exec(input int n, input int vmode, output int busy_n, output int beats,
                          output int early, output bit done_seen);
    int eb0, t;
    bit acc;
    eb0 = exec_beats; busy_n = 0; early = 0; t = 0;
    mode = 1;
    num_exec = 8'(n);
    src_data = {$urandom(), vmode == 0 ? 32'h87654321 : $urandom()};
    src_valid = 1; start_exec = 1;
    cyc();
    start_exec = 0;
    while (busy && t < 200) begin
      busy_n++;
      if (done) early++;
      acc = src_valid && src_ready;
      cyc();
      t++;
      if (acc && vmode != 0) src_data = {$urandom(), $urandom()};
      if (vmode == 2) src_valid = 1'($urandom_range(0, 1));
    end
    done_seen = done;
    src_valid = 0;
    cyc();
    beats = exec_beats - eb0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) cyc();
    ncmp++; if (in_w !== 32'h0) begin nerr++; $display("FAIL rst_in_w: got %h want 0", in_w); end
    ncmp++; if (inst_w !== 2'b00) begin nerr++; $display("FAIL rst_inst_w: got %b want 00", inst_w); end
    ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %b want 0", done); end
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
    ncmp++; if (src_ready !== 1'b0) begin nerr++; $display("FAIL rst_src_ready: got %b want 0", src_ready); end
    reset = 0;
    cyc();
  endtask

  task automatic test_load_full();
    int b, r, bt, e, w;
    bit d;
    run_load(0, 0, b, r, bt, e, d, w);
    ncmp++; if (bt !== 16) begin nerr++; $display("FAIL load_beats: got %0d want 16", bt); end
    ncmp++; if (w !== 8) begin nerr++; $display("FAIL load_words: got %0d want 8", w); end
    ncmp++; if (r !== 8) begin nerr++; $display("FAIL load_ready_cycles: got %0d want 8", r); end
    ncmp++; if (b !== 17) begin nerr++; $display("FAIL load_busy_cycles: got %0d want 17", b); end
    ncmp++; if (e !== 0) begin nerr++; $display("FAIL load_early_done: got %0d want 0", e); end
    ncmp++; if (d !== 1'b1) begin nerr++; $display("FAIL load_done_pulse: got %b want 1", d); end
    ncmp++; if (done !== 1'b0) begin nerr++; $display("FAIL load_done_width: got %b want 0", done); end
    ncmp++; if (load_q.size() !== 0) begin nerr++; $display("FAIL load_leftover: got %0d want 0", load_q.size()); end
  endtask

  task automatic test_load_toggle();
    int b, r, bt, e, w;
    bit d;
    run_load(1, 0, b, r, bt, e, d, w);
    ncmp++; if (bt !== 16) begin nerr++; $display("FAIL toggle_beats: got %0d want 16", bt); end
    ncmp++; if (b !== 24) begin nerr++; $display("FAIL toggle_busy_cycles: got %0d want 24", b); end
    ncmp++; if (d !== 1'b1) begin nerr++; $display("FAIL toggle_done: got %b want 1", d); end
  endtask

  task automatic test_exec();
    int b, bt, e;
    bit d;
    run_exec(5, 0, b, bt, e, d);
    ncmp++; if (bt !== 5) begin nerr++; $display("FAIL exec_beats: got %0d want 5", bt); end
    ncmp++; if (b !== 6) begin nerr++; $display("FAIL exec_busy_cycles: got %0d want 6", b); end
    ncmp++; if (e !== 0) begin nerr++; $display("FAIL exec_early_done: got %0d want 0", e); end
    ncmp++; if (d !== 1'b1) begin nerr++; $display("FAIL exec_done: got %b want 1", d); end
    run_exec(0, 0, b, bt, e, d);
    ncmp++; if (bt !== 0) begin nerr++; $display("FAIL exec0_beats: got %0d want 0", bt); end
    ncmp++; if (b !== 1) begin nerr++; $display("FAIL exec0_busy_cycles: got %0d want 1", b); end
    ncmp++; if (d !== 1'b1) begin nerr++; $display("FAIL exec0_done: got %b want 1", d); end
  endtask

  task automatic test_start_conflict();
    int b, r, bt, e, w, eb0;
    bit d;
    eb0 = exec_beats;
    run_load(0, 1, b, r, bt, e, d, w);
    repeat (3) cyc();
    ncmp++; if (bt !== 16) begin nerr++; $display("FAIL conflict_load_beats: got %0d want 16", bt); end
    ncmp++; if (exec_beats - eb0 !== 0) begin nerr++; $display("FAIL conflict_exec_beats: got %0d want 0", exec_beats - eb0); end
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL conflict_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int b, r, bt, e, w;
    bit d, acc;
    mode = 0; w = 0;
    src_valid = 1; src_data = wordk(0); start_load = 1;
    cyc();
    start_load = 0;
    for (int t = 0; t < 7; t++) begin
      acc = src_ready;
      cyc();
      if (acc) begin w++; src_data = wordk(w); end
    end
    ncmp++; if ({busy, src_ready} !== 2'b10) begin nerr++; $display("FAIL mid_in_load_b: got %b want 10", {busy, src_ready}); end
    reset = 1;
    cyc();
    reset = 0; src_valid = 0;
    ncmp++; if (inst_w !== 2'b00) begin nerr++; $display("FAIL mid_inst_w: got %b want 00", inst_w); end
    ncmp++; if (in_w !== 32'h0) begin nerr++; $display("FAIL mid_in_w: got %h want 0", in_w); end
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL mid_busy: got %b want 0", busy); end
    cyc();
    run_load(0, 0, b, r, bt, e, d, w);
    ncmp++; if (bt !== 16) begin nerr++; $display("FAIL mid_restart_beats: got %0d want 16", bt); end
    ncmp++; if (b !== 17) begin nerr++; $display("FAIL mid_restart_busy: got %0d want 17", b); end
  endtask

  task automatic test_random();
    int b, r, bt, e, w, n;
    bit d;
    for (int k = 0; k < 13; k++) begin
      run_load(2, 0, b, r, bt, e, d, w);
      ncmp++; if (bt !== 16) begin nerr++; $display("FAIL rand_load_beats[%0d]: got %0d want 16", k, bt); end
    end
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 20);
      run_exec(n, 2, b, bt, e, d);
      ncmp++; if (bt !== n) begin nerr++; $display("FAIL rand_exec_beats[%0d]: got %0d want %0d", k, bt, n); end
    end
  endtask

  initial begin
    reset = 1; start_load = 0; start_exec = 0; num_exec = 0;
    src_data = 0; src_valid = 0; mode = 0; pend = 0;
    ncmp = 0; nerr = 0; load_beats = 0; exec_beats = 0;
    fork
      forever begin
        @(negedge clk);
        if (inst_w === 2'b01) load_beats++;
        if (inst_w === 2'b10) exec_beats++;
        if (pend) begin
          pend = 0;
          ncmp++;
          if (inst_w !== 2'b01) begin
            nerr++; $display("FAIL pair_split: inst_w %b want 01", inst_w);
          end else if (load_q.size() == 0) begin
            nerr++; $display("FAIL load_unexpected: beat %h with no source word", in_w);
          end else begin
            for (int i = 0; i < 8; i++) rec[8*i +: 8] = {in_w[4*i +: 4], first_b[4*i +: 4]};
            expw = load_q.pop_front();
            if (rec !== expw) begin nerr++; $display("FAIL load_pair: got %h want %h", rec, expw); end
          end
        end else if (inst_w === 2'b01) begin
          first_b = in_w;
          pend = 1;
        end
        if (inst_w === 2'b10) begin
          ncmp++;
          if (exec_q.size() == 0) begin
            nerr++; $display("FAIL exec_unexpected: beat %h with no source word", in_w);
          end else begin
            expe = exec_q.pop_front();
            if (in_w !== expe) begin nerr++; $display("FAIL exec_beat: got %h want %h", in_w, expe); end
          end
        end
        if (reset) begin
          pend = 0;
          load_q.delete();
          exec_q.delete();
        end else if (src_valid && src_ready) begin
          if (mode == 0) load_q.push_back(src_data);
          else exec_q.push_back(src_data[31:0]);
        end
      end
    join_none
    test_reset();
    test_load_full();
    test_load_toggle();
    test_exec();
    test_start_conflict();
    test_reset_mid();
    test_random();
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
